onchip_mem_test_master: RTL and testbench

- Avalon-MM initiator that drives the s1 port of the on-chip RAM slave (single-port altsyncram, 32-bit data, word addressing, unregistered output, fixed read latency 1, no waitrequest).
- Fills a word range with a deterministic pattern, then optionally reads the range back and compares each word.
- Used for power-on RAM self-test and for clearing or seeding the RAM before the Nios core is released.
- Reports busy, a one-cycle done pulse, the mismatch count and the first failing address.

---
 rtl/onchip_mem_test_master.sv | 211 +++++++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM fill/verify initiator for the on-chip RAM s1 port (read latency 1, no waitrequest).
// Define MEMTEST_LFSR_EN to use a Galois LFSR data pattern instead of seed + i.
module onchip_mem_test_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              verify,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              err_flag,
   output logic [ADDR_W-1:0] m_address,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_clken,
   input  logic [DATA_W-1:0] m_readdata
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_N = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ZERO_N = {(ADDR_W+1){1'b0}};
   localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
`ifdef MEMTEST_LFSR_EN
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h80200003);
`endif

   function automatic logic [DATA_W-1:0] pat_init(input logic [DATA_W-1:0] s);
`ifdef MEMTEST_LFSR_EN
      // An all-zero LFSR state would lock up, so a zero seed starts at 1.
      return (s == ZERO_D) ? ONE_D : s;
`else
      return s;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] p);
`ifdef MEMTEST_LFSR_EN
      return p[0] ? ({1'b0, p[DATA_W-1:1]} ^ LFSR_TAPS) : {1'b0, p[DATA_W-1:1]};
`else
      return p + ONE_D;
`endif
   endfunction

   logic [2:0]        state_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W:0]   num_r;
   logic [ADDR_W:0]   idx_r;
   logic              verify_r;
   logic [DATA_W-1:0] seed_r;
   logic [DATA_W-1:0] pat_r;
   logic              busy_r;
   logic              done_r;
   logic [ADDR_W-1:0] m_address_r;
   logic              m_chipselect_r;
   logic              m_write_r;
   logic [DATA_W-1:0] m_writedata_r;
   logic              cmp_valid_r;
   logic [DATA_W-1:0] exp_r;
   logic [ADDR_W-1:0] exp_addr_r;
   logic [ADDR_W:0]   err_count_r;
   logic [ADDR_W-1:0] first_err_addr_r;
   logic              err_flag_r;
   logic [ADDR_W:0]   last_idx_s;

   assign last_idx_s     = num_r - ONE_N;
   assign busy           = busy_r;
   assign done           = done_r;
   assign err_count      = err_count_r;
   assign first_err_addr = first_err_addr_r;
   assign err_flag       = err_flag_r;
   assign m_address      = m_address_r;
   assign m_chipselect   = m_chipselect_r;
   assign m_write        = m_write_r;
   assign m_writedata    = m_writedata_r;
   assign m_byteenable   = 4'hF;
   assign m_clken        = 1'b1;

   // Sequencer: walks the word range, driving one bus access per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         base_r         <= {ADDR_W{1'b0}};
         num_r          <= ZERO_N;
         idx_r          <= ZERO_N;
         verify_r       <= 1'b0;
         seed_r         <= ZERO_D;
         pat_r          <= ZERO_D;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         m_address_r    <= {ADDR_W{1'b0}};
         m_chipselect_r <= 1'b0;
         m_write_r      <= 1'b0;
         m_writedata_r  <= ZERO_D;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  base_r   <= base_addr;
                  num_r    <= num_words;
                  verify_r <= verify;
                  seed_r   <= seed;
                  idx_r    <= ZERO_N;
                  if (num_words == ZERO_N) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r        <= ST_WRITE;
                     busy_r         <= 1'b1;
                     m_chipselect_r <= 1'b1;
                     m_write_r      <= 1'b1;
                     m_address_r    <= base_addr;
                     m_writedata_r  <= pat_init(seed);
                     pat_r          <= pat_init(seed);
                  end
               end
            end
            ST_WRITE: begin
               if (idx_r == last_idx_s) begin
                  idx_r     <= ZERO_N;
                  m_write_r <= 1'b0;
                  if (verify_r) begin
                     state_r     <= ST_READ;
                     m_address_r <= base_r;
                     pat_r       <= pat_init(seed_r);
                  end else begin
                     state_r        <= ST_DONE;
                     m_chipselect_r <= 1'b0;
                     busy_r         <= 1'b0;
                     done_r         <= 1'b1;
                  end
               end else begin
                  idx_r         <= idx_r + ONE_N;
                  m_address_r   <= m_address_r + ONE_A;
                  pat_r         <= pat_step(pat_r);
                  m_writedata_r <= pat_step(pat_r);
               end
            end
            ST_READ: begin
               if (idx_r == last_idx_s) begin
                  state_r        <= ST_DRAIN;
                  m_chipselect_r <= 1'b0;
               end else begin
                  idx_r       <= idx_r + ONE_N;
                  m_address_r <= m_address_r + ONE_A;
                  pat_r       <= pat_step(pat_r);
               end
            end
            ST_DRAIN: begin
               state_r <= ST_DONE;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               busy_r         <= 1'b0;
               done_r         <= 1'b0;
               m_chipselect_r <= 1'b0;
               m_write_r      <= 1'b0;
            end
         endcase
      end
   end

   // Checker: delays expected word/address by one stage to line up with readdata.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_valid_r      <= 1'b0;
         exp_r            <= ZERO_D;
         exp_addr_r       <= {ADDR_W{1'b0}};
         err_count_r      <= ZERO_N;
         first_err_addr_r <= {ADDR_W{1'b0}};
         err_flag_r       <= 1'b0;
      end else begin
         cmp_valid_r <= (state_r == ST_READ);
         exp_r       <= pat_r;
         exp_addr_r  <= m_address_r;
         if ((state_r == ST_IDLE) && start) begin
            err_count_r      <= ZERO_N;
            first_err_addr_r <= {ADDR_W{1'b0}};
            err_flag_r       <= 1'b0;
         end else if (cmp_valid_r && (m_readdata != exp_r)) begin
            err_count_r <= err_count_r + ONE_N;
            if (!err_flag_r) begin
               first_err_addr_r <= exp_addr_r;
               err_flag_r       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Randomized bench for onchip_mem_test_master: RAM slave model plus a cycle-level
// expectation model derived from the operation's start parameters.
module tb_onchip_mem_test_master;

   logic        clk = 1'b0;
   logic        reset, start, verify;
   logic [15:0] base_addr;
   logic [16:0] num_words;
   logic [31:0] seed;
   logic        busy, done, err_flag;
   logic [16:0] err_count;
   logic [15:0] first_err_addr, m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write, m_clken;
   logic [31:0] m_writedata, m_readdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   onchip_mem_test_master #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .verify(verify),
      .base_addr(base_addr), .num_words(num_words), .seed(seed),
      .busy(busy), .done(done), .err_count(err_count),
      .first_err_addr(first_err_addr), .err_flag(err_flag),
      .m_address(m_address), .m_byteenable(m_byteenable),
      .m_chipselect(m_chipselect), .m_write(m_write),
      .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
   );

   // RAM slave model: registered read, optional stuck-at-1 on bit 3 of one word.
   logic [31:0] ram_mem [0:65535];
   logic [31:0] ram_rd;
   logic        fault_en = 1'b0;
   logic [15:0] fault_addr = 16'h0000;
   logic [15:0] wlog_addr [$];
   logic [31:0] wlog_data [$];
   assign m_readdata = ram_rd;

   always @(posedge clk) begin
      if (m_chipselect && m_write) begin
         ram_mem[m_address] <= m_writedata;
         wlog_addr.push_back(m_address);
         wlog_data.push_back(m_writedata);
      end else if (m_chipselect) begin
         ram_rd <= (fault_en && m_address == fault_addr) ?
                   (ram_mem[m_address] | 32'h0000_0008) : ram_mem[m_address];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_pat(input logic [31:0] s, input int i);
      logic [31:0] p;
`ifdef MEMTEST_LFSR_EN
      p = (s == 32'h0) ? 32'h1 : s;
      for (int k = 0; k < i; k++)
         p = p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
      p = s + 32'(i);
`endif
      return p;
   endfunction

   // Operation under test, as latched at the accepted start.
   logic        op_verify;
   logic [15:0] op_base;
   int          op_n, op_dc;
   logic [31:0] pat [0:63];
   bit          mm  [0:63];
   logic        mon_en = 1'b0;
   int          mon_cyc, done_cyc, cs_cnt;

   // Compare process: one check set per cycle after the accepted start.
   always @(negedge clk) begin
      int c, cnt;
      logic [15:0] fa;
      logic e_w, e_cs;
      if (mon_en) begin
         mon_cyc = mon_cyc + 1;
         c    = mon_cyc;
         e_w  = (c <= op_n);
         e_cs = e_w || (op_verify && c <= 2 * op_n);
         cnt  = 0;
         fa   = 16'h0000;
         for (int j = 0; j < op_n; j++)
            if (mm[j] && (op_n + 3 + j <= c)) begin
               if (cnt == 0) fa = 16'(op_base + 16'(j));
               cnt++;
            end
         chk("chipselect", m_chipselect, e_cs);
         chk("write", m_write, e_w);
         chk("busy", busy, (op_n > 0) && (c < op_dc));
         chk("done", done, c == op_dc);
         chk("byteenable", m_byteenable, 4'hF);
         chk("clken", m_clken, 1'b1);
         if (e_cs)
            chk("address", m_address,
                e_w ? 16'(op_base + 16'(c - 1)) : 16'(op_base + 16'(c - op_n - 1)));
         if (e_w) chk("writedata", m_writedata, pat[c-1]);
         chk("err_count", err_count, cnt);
         chk("err_flag", err_flag, cnt > 0);
         chk("first_err_addr", first_err_addr, fa);
         if (m_chipselect) cs_cnt++;
         if (done && done_cyc < 0) done_cyc = c;
      end
   end

   task automatic run_op(input logic v, input logic [15:0] b, input int n,
                         input logic [31:0] s, input logic fe, input logic [15:0] fa);
      @(negedge clk);
      verify = v; base_addr = b; num_words = 17'(n); seed = s; start = 1'b1;
      op_verify = v; op_base = b; op_n = n;
      fault_en = fe; fault_addr = fa;
      for (int j = 0; j < 64; j++) begin
         pat[j] = ref_pat(s, j);
         mm[j]  = v && fe && (j < n) && (16'(b + 16'(j)) == fa) && !pat[j][3];
      end
      op_dc = (n == 0) ? 1 : (v ? 2 * n + 2 : n + 1);
      mon_cyc = 0; done_cyc = -1; cs_cnt = 0;
      wlog_addr.delete(); wlog_data.delete();
      @(posedge clk); #1;
      mon_en = 1'b1;
      // Starts and input changes during the run must be ignored.
      for (int k = 1; k <= op_dc + 1; k++) begin
         start     = (k <= op_dc) && ($urandom_range(0, 3) == 0);
         verify    = 1'($urandom_range(0, 1));
         base_addr = 16'($urandom);
         num_words = 17'($urandom_range(0, 40));
         seed      = $urandom;
         @(posedge clk); #1;
      end
      mon_en = 1'b0;
      start  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; verify = 1'b0;
      base_addr = 16'h0; num_words = 17'h0; seed = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err_count", err_count, 17'h0);
      chk("rst_first_err_addr", first_err_addr, 16'h0);
      chk("rst_err_flag", err_flag, 1'b0);
      chk("rst_chipselect", m_chipselect, 1'b0);
      chk("rst_write", m_write, 1'b0);
      chk("rst_address", m_address, 16'h0);
      chk("rst_writedata", m_writedata, 32'h0);
      @(negedge clk); reset = 1'b0;

      // Fill only
      run_op(1'b0, 16'h0010, 4, 32'hA000_0000, 1'b0, 16'h0);
      chk("fill_done_cycle", done_cyc, 5);
      chk("fill_nwrites", wlog_addr.size(), 4);
      if (wlog_addr.size() >= 4) begin
         chk("fill_addr0", wlog_addr[0], 16'h0010);
         chk("fill_addr3", wlog_addr[3], 16'h0013);
         chk("fill_data0", wlog_data[0], 32'hA000_0000);
`ifndef MEMTEST_LFSR_EN
         chk("fill_data3", wlog_data[3], 32'hA000_0003);
`endif
      end
      chk("fill_err_count", err_count, 17'h0);

      // Verify clean
      run_op(1'b1, 16'h0100, 8, 32'h1234_5670, 1'b0, 16'h0);
      chk("verify_done_cycle", done_cyc, 18);
      chk("verify_err_count", err_count, 17'h0);
      chk("verify_err_flag", err_flag, 1'b0);

      // Fault on bit 3 of word 0x0105
      run_op(1'b1, 16'h0100, 8, 32'h1234_5670, 1'b1, 16'h0105);
`ifndef MEMTEST_LFSR_EN
      chk("fault_err_count", err_count, 17'h1);
      chk("fault_first_addr", first_err_addr, 16'h0105);
      chk("fault_err_flag", err_flag, 1'b1);
`endif

      // Address wrap
      run_op(1'b1, 16'hFFFE, 4, $urandom, 1'b0, 16'h0);
      chk("wrap_nwrites", wlog_addr.size(), 4);
      if (wlog_addr.size() >= 4) begin
         chk("wrap_addr0", wlog_addr[0], 16'hFFFE);
         chk("wrap_addr1", wlog_addr[1], 16'hFFFF);
         chk("wrap_addr2", wlog_addr[2], 16'h0000);
         chk("wrap_addr3", wlog_addr[3], 16'h0001);
      end

      // Zero count
      run_op(1'b1, 16'h1234, 0, $urandom, 1'b0, 16'h0);
      chk("zero_done_cycle", done_cyc, 1);
      chk("zero_cs_count", cs_cnt, 0);

      // Reset during write of N=16
      @(negedge clk);
      verify = 1'b1; base_addr = 16'h2000; num_words = 17'd16; seed = 32'h5555_0000;
      fault_en = 1'b1; fault_addr = 16'h2000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      chk("pre_rst_chipselect", m_chipselect, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_chipselect", m_chipselect, 1'b0);
      chk("midrst_write", m_write, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_err_count", err_count, 17'h0);
      reset = 1'b0;
      fault_en = 1'b0;

      // Zero seed, N=3 verify
      run_op(1'b1, 16'h0000, 3, 32'h0, 1'b0, 16'h0);
      chk("lfsr_err_count", err_count, 17'h0);
`ifdef MEMTEST_LFSR_EN
      chk("lfsr_nwrites", wlog_data.size(), 3);
      if (wlog_data.size() >= 3) begin
         chk("lfsr_data0", wlog_data[0], 32'h0000_0001);
         chk("lfsr_data1", wlog_data[1], 32'h8020_0003);
         chk("lfsr_data2", wlog_data[2], 32'hC030_0002);
      end
`endif

      // Randomized operations
      for (int r = 0; r < 12; r++) begin
         int          n;
         logic [15:0] b;
         n = $urandom_range(0, 40);
         b = 16'($urandom);
         run_op(1'($urandom_range(0, 1)), b, n, $urandom,
                1'($urandom_range(0, 1)), 16'(b + 16'($urandom_range(0, n))));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
